freq_synth_nco: RTL and testbench



---
 rtl/freq_synth_nco.sv | 164 ++++++++++++++++
 tb/tb_freq_synth_nco.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_synth_nco.sv
// -----------------------------------------------------------------------------
// freq_synth_nco
// Numerically controlled square-wave generator. A requested output frequency
// (Hz) is converted into a phase-accumulator tuning word by a multi-cycle
// restoring divider:
//     word = floor(freq_hz * 2^ACC_W / CLK_FX)
// The new word is applied glitch-free at the next accumulator wrap.
//
// Optional build macro: FREQ_SYNTH_ROUND_EN
//   When defined, the divider produces one extra quotient bit and rounds the
//   result half-up. Every latency grows by one cycle.
//
// Ports:
//   clk_fx      in   system clock, frequency CLK_FX
//   rst_n       in   asynchronous active-low reset
//   freq_hz     in   requested output frequency in Hz (FREQ_W bits)
//   freq_valid  in   request strobe, sampled when freq_valid && freq_ready
//   freq_ready  out  high while idle and able to accept a request
//   range_err   out  one-cycle pulse: request rejected (freq_hz > CLK_FX/2)
//   tuning_word out  tuning word currently driving the accumulator
//   sq_out      out  registered accumulator MSB
//   tick        out  one-cycle pulse on accumulator carry-out
// -----------------------------------------------------------------------------
module freq_synth_nco #(
    parameter int CLK_FX = 50_000_000,
    parameter int ACC_W  = 32,
    parameter int FREQ_W = 32
) (
    input  logic              clk_fx,
    input  logic              rst_n,
    input  logic [FREQ_W-1:0] freq_hz,
    input  logic              freq_valid,
    output logic              freq_ready,
    output logic              range_err,
    output logic [ACC_W-1:0]  tuning_word,
    output logic              sq_out,
    output logic              tick
);

`ifdef FREQ_SYNTH_ROUND_EN
    localparam int DIV_CYC = ACC_W + 1;
`else
    localparam int DIV_CYC = ACC_W;
`endif
    localparam int CNT_W = $clog2(DIV_CYC + 1);

    localparam logic [FREQ_W:0]  CLK_K    = (FREQ_W+1)'(CLK_FX);
    localparam logic [FREQ_W:0]  HALF_K   = (FREQ_W+1)'(CLK_FX / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t             state_reg;
    logic               ready_reg;
    logic               range_err_reg;
    logic [ACC_W-1:0]   word_reg;
    logic [ACC_W-1:0]   pending_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               sq_reg;
    logic               tick_reg;
    logic [FREQ_W:0]    rem_reg;
    logic [DIV_CYC-1:0] quo_reg;
    logic [CNT_W-1:0]   cnt_reg;

    // One restoring-division step. rem_reg stays below CLK_FX, so the shifted
    // value always fits in FREQ_W+1 bits.
    logic [FREQ_W:0]    rem_shift;
    logic               q_bit;
    logic [FREQ_W:0]    rem_next;
    logic [DIV_CYC-1:0] quo_next;
    logic [ACC_W-1:0]   word_next;
    logic [ACC_W:0]     acc_sum;

    always_comb begin
        rem_shift = rem_reg << 1;
        q_bit     = (rem_shift >= CLK_K);
        rem_next  = q_bit ? (rem_shift - CLK_K) : rem_shift;
        quo_next  = {quo_reg[DIV_CYC-2:0], q_bit};
`ifdef FREQ_SYNTH_ROUND_EN
        // Extra LSB is the half bit: add it to round half-up.
        word_next = quo_next[DIV_CYC-1:1] + ACC_W'(quo_next[0]);
`else
        word_next = quo_next;
`endif
        acc_sum   = {1'b0, acc_reg} + {1'b0, word_reg};
    end

    // Phase accumulator. The add in the cycle where a new word is loaded
    // still uses the old word because word_reg updates at the same edge.
    always_ff @(posedge clk_fx or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            tick_reg <= 1'b0;
            sq_reg   <= 1'b0;
        end else begin
            acc_reg  <= acc_sum[ACC_W-1:0];
            tick_reg <= acc_sum[ACC_W];
            sq_reg   <= acc_sum[ACC_W-1];
        end
    end

    // Request / divide / apply control.
    always_ff @(posedge clk_fx or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ready_reg     <= 1'b1;
            range_err_reg <= 1'b0;
            word_reg      <= '0;
            pending_reg   <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            cnt_reg       <= '0;
        end else begin
            range_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (freq_valid && ready_reg) begin
                        if ({1'b0, freq_hz} > HALF_K) begin
                            range_err_reg <= 1'b1;
                        end else begin
                            rem_reg   <= {1'b0, freq_hz};
                            quo_reg   <= '0;
                            cnt_reg   <= '0;
                            ready_reg <= 1'b0;
                            state_reg <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        pending_reg <= word_next;
                        state_reg   <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    // A stopped accumulator has no wrap to wait for.
                    if (word_reg == '0 || tick_reg) begin
                        word_reg  <= pending_reg;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign freq_ready  = ready_reg;
    assign range_err   = range_err_reg;
    assign tuning_word = word_reg;
    assign sq_out      = sq_reg;
    assign tick        = tick_reg;

endmodule

// File: tb/tb_freq_synth_nco.sv
module tb_freq_synth_nco;

    logic        clk_fx = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] freq_hz = '0;
    logic        freq_valid = 1'b0;
    logic        freq_ready;
    logic        range_err;
    logic [31:0] tuning_word;
    logic        sq_out;
    logic        tick;

    freq_synth_nco #(
        .CLK_FX(50_000_000),
        .ACC_W (32),
        .FREQ_W(32)
    ) dut (
        .clk_fx     (clk_fx),
        .rst_n      (rst_n),
        .freq_hz    (freq_hz),
        .freq_valid (freq_valid),
        .freq_ready (freq_ready),
        .range_err  (range_err),
        .tuning_word(tuning_word),
        .sq_out     (sq_out),
        .tick       (tick)
    );

    always #5 clk_fx = ~clk_fx;

    // 2^32/50 = 85899345.92, 2^32/25 = 171798691.84
`ifdef FREQ_SYNTH_ROUND_EN
    localparam logic [31:0] W1M = 32'd85899346;
    localparam logic [31:0] W2M = 32'd171798692;
    localparam int          LAT = 35;
`else
    localparam logic [31:0] W1M = 32'd85899345;
    localparam logic [31:0] W2M = 32'd171798691;
    localparam int          LAT = 34;
`endif
    localparam logic [31:0] WHALF = 32'h8000_0000;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after accept.
    task automatic request(input logic [31:0] f);
        int n;
        n = 0;
        while (freq_ready !== 1'b1 && n < 1000) begin
            @(negedge clk_fx);
            n++;
        end
        chk("ready_before_req", {63'd0, freq_ready}, 64'd1);
        freq_hz    = f;
        freq_valid = 1'b1;
        @(posedge clk_fx);
        @(negedge clk_fx);
        freq_valid = 1'b0;
        $display("request freq_hz=%0d accepted", f);
    endtask

    // Cycle index (accept = cycle 0) at which tuning_word first equals exp.
    task automatic wait_word(input logic [31:0] exp, output int cyc);
        cyc = 1;
        while (tuning_word !== exp && cyc < 300) begin
            @(negedge clk_fx);
            cyc++;
        end
    endtask

    // Observes loads, sq_out run lengths and tick spacing for ncyc cycles.
    task automatic monitor(input int ncyc, output int loads, output int bad_loads,
                           output int min_run, output int last_space);
        logic [31:0] prev_word;
        logic        prev_tick, prev_sq, seen_edge;
        int          run, last_tick;
        prev_word = tuning_word; prev_tick = tick; prev_sq = sq_out;
        seen_edge = 1'b0; run = 0; last_tick = -1;
        loads = 0; bad_loads = 0; min_run = 1_000_000; last_space = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk_fx);
            if (tuning_word !== prev_word) begin
                loads++;
                if (prev_tick !== 1'b1) bad_loads++;
            end
            if (sq_out !== prev_sq) begin
                if (seen_edge && run < min_run) min_run = run;
                seen_edge = 1'b1;
                run = 1;
            end else begin
                run++;
            end
            if (tick === 1'b1) begin
                if (last_tick >= 0) last_space = i - last_tick;
                last_tick = i;
            end
            prev_word = tuning_word; prev_tick = tick; prev_sq = sq_out;
        end
    endtask

    initial begin
        int cyc, bad, cnt, loads, bad_loads, min_run, space;

        // 1: reset, then idle for 1000 cycles
        repeat (3) @(negedge clk_fx);
        chk("rst_ready", {63'd0, freq_ready}, 64'd1);
        chk("rst_word", {32'd0, tuning_word}, 64'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_fx);
            if (freq_ready !== 1'b1 || sq_out !== 1'b0 || tick !== 1'b0 ||
                tuning_word !== 32'd0 || range_err !== 1'b0) bad++;
        end
        chk("idle_1000_bad_cycles", bad, 0);
        $display("idle 1000 cycles, bad=%0d", bad);

        // 2: 1 MHz from stopped
        request(32'd1_000_000);
        chk("div_ready_low", {63'd0, freq_ready}, 64'd0);
        wait_word(W1M, cyc);
        chk("w1m_word", {32'd0, tuning_word}, {32'd0, W1M});
        chk("w1m_latency", cyc, LAT);
        chk("w1m_ready", {63'd0, freq_ready}, 64'd1);
        cnt = 0;
        for (int i = 0; i < 50_000; i++) begin
            @(negedge clk_fx);
            if (tick === 1'b1) cnt++;
        end
        chk("w1m_ticks_in_range", {63'd0, (cnt >= 999 && cnt <= 1001)}, 64'd1);
        $display("1 MHz: word=%0d latency=%0d ticks=%0d", tuning_word, cyc, cnt);

        // 4: running 1 MHz -> 2 MHz, glitch-free switch
        request(32'd2_000_000);
        monitor(3000, loads, bad_loads, min_run, space);
        chk("w2m_word", {32'd0, tuning_word}, {32'd0, W2M});
        chk("w2m_loads", loads, 1);
        chk("w2m_load_on_tick", bad_loads, 0);
        chk("w2m_min_phase_ge12", {63'd0, (min_run >= 12)}, 64'd1);
        chk("w2m_tick_space", {63'd0, (space >= 24 && space <= 26)}, 64'd1);
        $display("2 MHz: word=%0d loads=%0d min_run=%0d spacing=%0d",
                 tuning_word, loads, min_run, space);

        // 5: running -> 0 Hz, freeze after wrap
        request(32'd0);
        monitor(200, loads, bad_loads, min_run, space);
        chk("w0_word", {32'd0, tuning_word}, 64'd0);
        chk("w0_load_on_tick", {63'd0, (loads == 1 && bad_loads == 0)}, 64'd1);
        bad = 0;
        for (int i = 0; i < 10_000; i++) begin
            @(negedge clk_fx);
            if (sq_out !== 1'b0 || tick !== 1'b0) bad++;
        end
        chk("w0_frozen_bad_cycles", bad, 0);
        $display("0 Hz: word=%0d frozen bad=%0d", tuning_word, bad);

        // 3: CLK_FX/2 from stopped, then out-of-range request
        request(32'd25_000_000);
        wait_word(WHALF, cyc);
        chk("whalf_word", {32'd0, tuning_word}, {32'd0, WHALF});
        chk("whalf_latency", cyc, LAT);
        repeat (2) @(negedge clk_fx);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            logic p;
            p = sq_out;
            @(negedge clk_fx);
            if (sq_out === p) bad++;
        end
        chk("whalf_toggle_bad", bad, 0);
        $display("25 MHz: word=%0h toggle bad=%0d", tuning_word, bad);

        request(32'd25_000_001);
        chk("rerr_pulse", {63'd0, range_err}, 64'd1);
        chk("rerr_ready_c1", {63'd0, freq_ready}, 64'd1);
        @(negedge clk_fx);
        chk("rerr_one_cycle", {63'd0, range_err}, 64'd0);
        chk("rerr_ready_c2", {63'd0, freq_ready}, 64'd1);
        repeat (40) @(negedge clk_fx);
        chk("rerr_word_kept", {32'd0, tuning_word}, {32'd0, WHALF});
        $display("25000001 Hz: range_err seen, word=%0h", tuning_word);

        // 6: reset in the middle of DIV
        request(32'd1_000_000);
        repeat (9) @(negedge clk_fx);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {63'd0, freq_ready}, 64'd1);
        chk("mid_rst_word", {32'd0, tuning_word}, 64'd0);
        chk("mid_rst_outs", {61'd0, sq_out, tick, range_err}, 64'd0);
        repeat (2) @(negedge clk_fx);
        rst_n = 1'b1;
        @(negedge clk_fx);
        chk("post_rst_ready", {63'd0, freq_ready}, 64'd1);
        request(32'd1_000_000);
        wait_word(W1M, cyc);
        chk("post_rst_word", {32'd0, tuning_word}, {32'd0, W1M});
        chk("post_rst_latency", cyc, LAT);
        $display("post-reset 1 MHz: word=%0d latency=%0d", tuning_word, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
